// File: rtl/mac_tx_pkg.sv
// Shared types and constants for the MAC TX frame arbiter.
package mac_tx_pkg;

  // MAC byte interface
  localparam int DATA_W = 8;

  // Default timing / statistics parameters
  localparam int DEF_GAP_CYCLES = 16;
  localparam int DEF_TIMEOUT    = 255;
  localparam int DEF_CNT_W      = 16;

  // Source indices
  localparam logic SRC_IQ   = 1'b0;
  localparam logic SRC_CTRL = 1'b1;

  // Arbiter states
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_GRANT = 2'd1;
  localparam arb_state_t ST_GAP   = 2'd2;

  // One MAC beat, excluding the write strobe
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sop;
    logic              eop;
    logic              err;
  } mac_beat_t;

  // Round-robin pick: a lone requester wins; on a tie the source that was
  // not served last wins.
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic last);
    if (req0 && req1) return ~last;
    return req1;
  endfunction

endpackage

// File: rtl/mac_tx_watchdog.sv
// Stall watchdog for the granted source. Counts eligible cycles with no
// granted beat; expire_o fires on the cycle that would complete TIMEOUT such
// cycles, so the abort beat is registered on that same edge. A beat on the
// same cycle (clear_i) always wins over expiry.
module mac_tx_watchdog
  import mac_tx_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic eligible_i,
  output logic expire_o
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_q, wd_d;

  assign expire_o = eligible_i & ~clear_i & (wd_q == WD_LAST);

  // Next count: clear on a beat or outside GRANT, advance on eligible cycles
  always_comb begin
    wd_d = wd_q;
    if (clear_i || expire_o) begin
      wd_d = '0;
    end else if (eligible_i) begin
      wd_d = wd_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing the MAC TX byte interface
// between the IQ packetizer (source 0) and the control/ARP generator
// (source 1). Registered outputs, inter-frame gap, and a stall watchdog that
// terminates a wedged frame with an err beat.
//
// state | meaning
// IDLE  | no grant; pending requests are evaluated here only
// GRANT | one source owns the MAC; its beats are forwarded with latency 1
// GAP   | post-frame idle, GAP_CYCLES cycles, no grants, tx_wren=0
module mac_tx_arbiter
  import mac_tx_pkg::*;
#(
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  // source 0: IQ packetizer
  input  logic              s0_req_i,
  input  logic [DATA_W-1:0] s0_data_i,
  input  logic              s0_sop_i,
  input  logic              s0_eop_i,
  input  logic              s0_err_i,
  input  logic              s0_wren_i,
  output logic              s0_gnt_o,
  output logic              s0_rdy_o,
  // source 1: control/ARP generator
  input  logic              s1_req_i,
  input  logic [DATA_W-1:0] s1_data_i,
  input  logic              s1_sop_i,
  input  logic              s1_eop_i,
  input  logic              s1_err_i,
  input  logic              s1_wren_i,
  output logic              s1_gnt_o,
  output logic              s1_rdy_o,
  // MAC side
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_sop_o,
  output logic              tx_eop_o,
  output logic              tx_err_o,
  output logic              tx_wren_o,
  input  logic              tx_rdy_i,
  input  logic              tx_a_full_i,
  // statistics
  output logic [CNT_W-1:0]  s0_frames_o,
  output logic [CNT_W-1:0]  s1_frames_o,
  output logic [CNT_W-1:0]  abort_cnt_o
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
  // With no gap configured a finished or aborted frame returns straight to IDLE
  localparam arb_state_t ST_AFTER = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  arb_state_t       state_q, state_d;
  logic             last_q, last_d;
  logic             s0_gnt_q, s0_gnt_d;
  logic             s1_gnt_q, s1_gnt_d;
  logic             tx_wren_q, tx_wren_d;
  mac_beat_t        tx_beat_q, tx_beat_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] s0_frames_q, s0_frames_d;
  logic [CNT_W-1:0] s1_frames_q, s1_frames_d;
  logic [CNT_W-1:0] abort_cnt_q, abort_cnt_d;

  mac_beat_t s0_beat, s1_beat, g_beat;
  logic      in_grant;
  logic      g_wren;
  logic      mac_ok;
  logic      wd_clear;
  logic      wd_eligible;
  logic      wd_expire;
  logic      sel;

  assign s0_beat  = '{data: s0_data_i, sop: s0_sop_i, eop: s0_eop_i, err: s0_err_i};
  assign s1_beat  = '{data: s1_data_i, sop: s1_sop_i, eop: s1_eop_i, err: s1_err_i};
  assign g_beat   = s1_gnt_q ? s1_beat : s0_beat;
  assign in_grant = (state_q == ST_GRANT);
  assign g_wren   = in_grant & ((s0_gnt_q & s0_wren_i) | (s1_gnt_q & s1_wren_i));
  assign mac_ok   = tx_rdy_i & ~tx_a_full_i;

  // Backpressure holds the watchdog rather than advancing it
  assign wd_clear    = ~in_grant | g_wren;
  assign wd_eligible = in_grant & mac_ok & ~g_wren;

  mac_tx_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (wd_clear),
    .eligible_i (wd_eligible),
    .expire_o   (wd_expire)
  );

  // Arbitration, forwarding, gap timing and statistics next-state
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    s0_gnt_d    = s0_gnt_q;
    s1_gnt_d    = s1_gnt_q;
    tx_wren_d   = 1'b0;
    tx_beat_d   = '0;
    gap_d       = gap_q;
    s0_frames_d = s0_frames_q;
    s1_frames_d = s1_frames_q;
    abort_cnt_d = abort_cnt_q;
    sel         = rr_pick(s0_req_i, s1_req_i, last_q);

    case (state_q)
      ST_IDLE: begin
        if (s0_req_i || s1_req_i) begin
          last_d   = sel;
          s0_gnt_d = (sel == SRC_IQ);
          s1_gnt_d = (sel == SRC_CTRL);
          state_d  = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (g_wren) begin
          tx_wren_d = 1'b1;
          tx_beat_d = g_beat;
          if (g_beat.eop) begin
            s0_gnt_d = 1'b0;
            s1_gnt_d = 1'b0;
            if (s1_gnt_q) s1_frames_d = s1_frames_q + 1'b1;
            else          s0_frames_d = s0_frames_q + 1'b1;
            gap_d   = GAP_LOAD;
            state_d = ST_AFTER;
          end
        end else if (wd_expire) begin
          tx_wren_d = 1'b1;
          tx_beat_d = '{data: '0, sop: 1'b0, eop: 1'b1, err: 1'b1};
          s0_gnt_d  = 1'b0;
          s1_gnt_d  = 1'b0;
          if (abort_cnt_q != '1) abort_cnt_d = abort_cnt_q + 1'b1;
          gap_d   = GAP_LOAD;
          state_d = ST_AFTER;
        end
      end

      ST_GAP: begin
        // The counter reaching zero ends the gap, so GAP lasts GAP_CYCLES
        // cycles and the IDLE decision cycle brings spacing to GAP_CYCLES+1.
        gap_d = gap_q - 1'b1;
        if (gap_q <= GAP_W'(1)) begin
          gap_d   = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        s0_gnt_d = 1'b0;
        s1_gnt_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= SRC_CTRL;
      s0_gnt_q    <= 1'b0;
      s1_gnt_q    <= 1'b0;
      tx_wren_q   <= 1'b0;
      tx_beat_q   <= '0;
      gap_q       <= '0;
      s0_frames_q <= '0;
      s1_frames_q <= '0;
      abort_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      s0_gnt_q    <= s0_gnt_d;
      s1_gnt_q    <= s1_gnt_d;
      tx_wren_q   <= tx_wren_d;
      tx_beat_q   <= tx_beat_d;
      gap_q       <= gap_d;
      s0_frames_q <= s0_frames_d;
      s1_frames_q <= s1_frames_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign s0_gnt_o    = s0_gnt_q;
  assign s1_gnt_o    = s1_gnt_q;
  assign s0_rdy_o    = s0_gnt_q & mac_ok;
  assign s1_rdy_o    = s1_gnt_q & mac_ok;
  assign tx_wren_o   = tx_wren_q;
  assign tx_data_o   = tx_beat_q.data;
  assign tx_sop_o    = tx_beat_q.sop;
  assign tx_eop_o    = tx_beat_q.eop;
  assign tx_err_o    = tx_beat_q.err;
  assign s0_frames_o = s0_frames_q;
  assign s1_frames_o = s1_frames_q;
  assign abort_cnt_o = abort_cnt_q;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Bench for mac_tx_arbiter: cycle vectors for single-beat behaviour plus
// hand-written sequences for frames, ties, backpressure, watchdog and reset.
module tb_mac_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s0_req, s0_sop, s0_eop, s0_err, s0_wren;
  logic [7:0] s0_data;
  logic       s1_req, s1_sop, s1_eop, s1_err, s1_wren;
  logic [7:0] s1_data;
  logic       s0_gnt, s0_rdy, s1_gnt, s1_rdy;
  logic [7:0] tx_data;
  logic       tx_sop, tx_eop, tx_err, tx_wren;
  logic       tx_rdy, tx_a_full;
  logic [15:0] s0_frames, s1_frames, abort_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit seen_aa;

  always #5 clk = ~clk;

  mac_tx_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s0_req_i    (s0_req),
    .s0_data_i   (s0_data),
    .s0_sop_i    (s0_sop),
    .s0_eop_i    (s0_eop),
    .s0_err_i    (s0_err),
    .s0_wren_i   (s0_wren),
    .s0_gnt_o    (s0_gnt),
    .s0_rdy_o    (s0_rdy),
    .s1_req_i    (s1_req),
    .s1_data_i   (s1_data),
    .s1_sop_i    (s1_sop),
    .s1_eop_i    (s1_eop),
    .s1_err_i    (s1_err),
    .s1_wren_i   (s1_wren),
    .s1_gnt_o    (s1_gnt),
    .s1_rdy_o    (s1_rdy),
    .tx_data_o   (tx_data),
    .tx_sop_o    (tx_sop),
    .tx_eop_o    (tx_eop),
    .tx_err_o    (tx_err),
    .tx_wren_o   (tx_wren),
    .tx_rdy_i    (tx_rdy),
    .tx_a_full_i (tx_a_full),
    .s0_frames_o (s0_frames),
    .s1_frames_o (s1_frames),
    .abort_cnt_o (abort_cnt)
  );

  typedef struct packed {
    logic       s0_req, s1_req;
    logic       s0_w, s0_s, s0_e, s0_x;
    logic [7:0] s0_d;
    logic       s1_w, s1_e;
    logic [7:0] s1_d;
    logic       rdy, af;
    logic [1:0] e_gnt;   // {s0_gnt, s1_gnt}
    logic [1:0] e_rdy;   // {s0_rdy, s1_rdy}
    logic [3:0] e_tx;    // {wren, sop, eop, err}
    logic [7:0] e_data;  // checked only when wren=1
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(
    input logic s0r, input logic s1r,
    input logic s0w, input logic s0s, input logic s0e, input logic s0x,
    input logic [7:0] s0d,
    input logic s1w, input logic s1e, input logic [7:0] s1d,
    input logic rdy, input logic af,
    input logic [1:0] eg, input logic [1:0] er, input logic [3:0] et,
    input logic [7:0] ed);
    vec_t v;
    v.s0_req = s0r; v.s1_req = s1r;
    v.s0_w = s0w; v.s0_s = s0s; v.s0_e = s0e; v.s0_x = s0x; v.s0_d = s0d;
    v.s1_w = s1w; v.s1_e = s1e; v.s1_d = s1d;
    v.rdy = rdy; v.af = af;
    v.e_gnt = eg; v.e_rdy = er; v.e_tx = et; v.e_data = ed;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    s0_req = 0; s0_sop = 0; s0_eop = 0; s0_err = 0; s0_wren = 0; s0_data = 0;
    s1_req = 0; s1_sop = 0; s1_eop = 0; s1_err = 0; s1_wren = 0; s1_data = 0;
    tx_rdy = 1; tx_a_full = 0;
  endtask

  task automatic reset_dut(input string tag);
    clear_inputs();
    rst_n = 0;
    step();
    step();
    check({tag, "_reset_out"},
          {s0_gnt, s1_gnt, s0_rdy, s1_rdy, tx_wren, tx_sop, tx_eop, tx_err, tx_data}, 0);
    check({tag, "_reset_cnt"}, {s0_frames, s1_frames}, 0);
    rst_n = 1;
    step();
  endtask

  // Bench acting as the granted source: one beat per cycle, each checked on
  // the MAC side one edge later.
  task automatic send_frame(input bit src, input int n, input int base,
                            input bit do_sop, input bit do_eop, output int errs);
    logic [7:0] d;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      d = 8'(base + i);
      if (src) begin
        s1_wren = 1; s1_data = d; s1_sop = do_sop && (i == 0);
        s1_eop = do_eop && (i == n - 1); s1_err = 0;
      end else begin
        s0_wren = 1; s0_data = d; s0_sop = do_sop && (i == 0);
        s0_eop = do_eop && (i == n - 1); s0_err = 0;
      end
      step();
      if (tx_wren && tx_data == 8'hAA) seen_aa = 1;
      if (tx_wren !== 1'b1 || tx_data !== d || tx_err !== 1'b0 ||
          tx_sop !== (do_sop && (i == 0)) || tx_eop !== (do_eop && (i == n - 1)))
        errs++;
    end
    if (src) begin s1_wren = 0; s1_sop = 0; s1_eop = 0; end
    else     begin s0_wren = 0; s0_sop = 0; s0_eop = 0; end
  endtask

  // Counts sampled cycles with no grant, including the current one.
  task automatic wait_gnt(output int lowcnt, output int who);
    lowcnt = 0;
    while (!(s0_gnt || s1_gnt) && lowcnt < 300) begin
      lowcnt++;
      step();
    end
    who = s1_gnt ? 1 : (s0_gnt ? 0 : -1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int errs, errs2, low, who, cnt;

    //           s0r s1r s0w s0s s0e s0x s0d    s1w s1e s1d    rdy af  gnt    rdy    tx       data
    vecs[0] = mk(1,  0,  0,  0,  0,  0,  8'h00, 0,  0,  8'h00, 1,  0,  2'b10, 2'b10, 4'b0000, 8'h00);
    vecs[1] = mk(1,  0,  1,  1,  0,  0,  8'h11, 1,  1,  8'hAA, 1,  0,  2'b10, 2'b10, 4'b1100, 8'h11);
    vecs[2] = mk(1,  0,  0,  0,  0,  0,  8'h00, 0,  0,  8'h00, 1,  1,  2'b10, 2'b00, 4'b0000, 8'h00);
    vecs[3] = mk(1,  0,  1,  0,  0,  1,  8'h22, 0,  0,  8'h00, 0,  0,  2'b10, 2'b00, 4'b1001, 8'h22);
    vecs[4] = mk(1,  0,  1,  1,  0,  0,  8'h33, 0,  0,  8'h00, 1,  0,  2'b10, 2'b10, 4'b1100, 8'h33);
    vecs[5] = mk(0,  1,  1,  0,  1,  0,  8'h44, 0,  0,  8'h00, 1,  0,  2'b00, 2'b00, 4'b1010, 8'h44);
    vecs[6] = mk(0,  1,  0,  0,  0,  0,  8'h00, 1,  0,  8'h55, 1,  0,  2'b00, 2'b00, 4'b0000, 8'h00);

    // Vector table
    reset_dut("vec");
    for (int i = 0; i < 7; i++) begin
      s0_req = vecs[i].s0_req; s1_req = vecs[i].s1_req;
      s0_wren = vecs[i].s0_w; s0_sop = vecs[i].s0_s; s0_eop = vecs[i].s0_e;
      s0_err = vecs[i].s0_x; s0_data = vecs[i].s0_d;
      s1_wren = vecs[i].s1_w; s1_sop = vecs[i].s1_e; s1_eop = vecs[i].s1_e;
      s1_data = vecs[i].s1_d;
      tx_rdy = vecs[i].rdy; tx_a_full = vecs[i].af;
      step();
      check($sformatf("vec%0d", i),
            {s0_gnt, s1_gnt, s0_rdy, s1_rdy, tx_wren, tx_sop, tx_eop, tx_err,
             (tx_wren ? tx_data : 8'h00)},
            {vecs[i].e_gnt, vecs[i].e_rdy, vecs[i].e_tx,
             (vecs[i].e_tx[3] ? vecs[i].e_data : 8'h00)});
    end
    check("vec_counters", {s0_frames, s1_frames, abort_cnt}, {16'd1, 16'd0, 16'd0});

    // Single source, 60-byte frame
    reset_dut("single");
    s0_req = 1;
    step();
    check("single_gnt_latency", {s0_gnt, s1_gnt}, 2'b10);
    s0_req = 0;
    send_frame(0, 60, 0, 1, 1, errs);
    check("single_bytes", errs, 0);
    check("single_gnt_drop", s0_gnt, 0);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (tx_wren) cnt++;
    end
    check("single_idle_after", cnt, 0);
    check("single_frames", {s0_frames, s1_frames}, {16'd1, 16'd0});

    // Tie from reset: alternating grants with gap spacing
    reset_dut("tie");
    s0_req = 1; s1_req = 1;
    for (int f = 0; f < 4; f++) begin
      wait_gnt(low, who);
      check($sformatf("tie_order%0d", f), who, f % 2);
      if (f > 0) check($sformatf("tie_spacing%0d", f), low, 17);
      if (who >= 0) begin
        send_frame(who[0], 5, 16 * f + 1, 1, 1, errs);
        check($sformatf("tie_bytes%0d", f), errs, 0);
      end
    end
    check("tie_frames", {s0_frames, s1_frames}, {16'd2, 16'd2});

    // Backpressure mid-frame with an intruding source 1
    reset_dut("bp");
    seen_aa = 0;
    s0_req = 1;
    s1_wren = 1; s1_data = 8'hAA; s1_sop = 1; s1_eop = 1;
    step();
    send_frame(0, 10, 8'h10, 1, 0, errs);
    tx_a_full = 1;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (s0_rdy !== 1'b0 || tx_wren !== 1'b0) cnt++;
    end
    check("bp_stall", cnt, 0);
    tx_a_full = 0;
    send_frame(0, 10, 8'h1A, 0, 1, errs2);
    check("bp_bytes", errs + errs2, 0);
    check("bp_abort_cnt", abort_cnt, 0);
    check("bp_frames", s0_frames, 1);
    check("bp_intruder", seen_aa, 0);
    clear_inputs();

    // Watchdog: one late beat right at the limit survives, then an abort
    reset_dut("wd");
    s1_req = 1;
    wait_gnt(low, who);
    check("wd_gnt", who, 1);
    s1_req = 0;
    send_frame(1, 10, 8'h40, 1, 0, errs);
    check("wd_bytes", errs, 0);
    cnt = 0;
    for (int i = 0; i < 254; i++) begin
      step();
      if (tx_wren) cnt++;
    end
    check("wd_quiet", cnt, 0);
    send_frame(1, 1, 8'h4A, 0, 0, errs);
    check("wd_boundary_beat", errs, 0);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!tx_wren && cnt < 400);
    check("wd_abort_delay", cnt, 255);
    check("wd_abort_beat", {tx_wren, tx_sop, tx_eop, tx_err, tx_data}, 12'b1_0_1_1_00000000);
    check("wd_gnt_drop", {s0_gnt, s1_gnt}, 2'b00);
    check("wd_counts", {abort_cnt, s1_frames}, {16'd1, 16'd0});
    step();
    check("wd_single_err_beat", tx_wren, 0);

    // Asynchronous reset in the middle of a frame
    reset_dut("arst");
    s0_req = 1;
    step();
    send_frame(0, 3, 8'h60, 1, 0, errs);
    s0_wren = 1; s0_data = 8'h63;
    step();
    check("arst_pre", {tx_wren, tx_data, s0_gnt}, {1'b1, 8'h63, 1'b1});
    rst_n = 0;
    #2;
    check("arst_immediate",
          {s0_gnt, s1_gnt, tx_wren, tx_sop, tx_eop, tx_err, tx_data}, 0);
    clear_inputs();
    s0_req = 1; s1_req = 1;
    rst_n = 1;
    step();
    check("arst_first_gnt", {s0_gnt, s1_gnt}, 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
